// File: rtl/core_pkg.sv
// core_pkg: types and constants shared by the core pipeline stages.
//   rob_tag_t : ROB completion index (CORE_TAG_W bits)
//   exc_t     : exception vector (CORE_EXC_W bits)
//   EXC_NONE  : "no exception" code
package core_pkg;

  localparam int CORE_TAG_W = 4;
  localparam int CORE_EXC_W = 3;

  typedef logic [CORE_TAG_W-1:0] rob_tag_t;
  typedef logic [CORE_EXC_W-1:0] exc_t;

  localparam exc_t EXC_NONE = '0;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: bundle of the pipeline-stage handshake, payload, flush
// and drop-count signals.
//   slave  : the stage register's view (consumes in_*, produces out_*)
//   master : the surrounding logic's view (produces in_*, consumes out_*)
//
// Handshake: a beat moves across a boundary on a clock edge exactly when
// valid && ready are both high in that cycle. A producer holding valid keeps
// its payload stable until the transfer; ready says nothing about the
// payload and may be high with valid low.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 4,
  parameter int EXC_W  = 3,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [TAG_W-1:0]  in_tag;
  logic [EXC_W-1:0]  in_exc;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic [EXC_W-1:0]  out_exc;
  logic [CNT_W-1:0]  drop_count;

  modport slave (
    input  in_valid, in_data, in_tag, in_exc, flush, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_exc, drop_count
  );

  modport master (
    output in_valid, in_data, in_tag, in_exc, flush, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_exc, drop_count
  );
endinterface

// File: rtl/pipe_skid_entry.sv
// pipe_skid_entry: one valid bit plus a W-bit payload register.
//   clk, rst_n : clock, asynchronous active-low reset (valid and payload -> 0)
//   clear_i    : drop the held beat (valid -> 0); wins over load_i
//   load_i     : capture valid_i / data_i
//   valid_o    : held beat is valid
//   data_o     : held payload (kept across clear_i)
module pipe_skid_entry #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = valid_i;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: flow-controlled pipeline stage register carrying payload,
// ROB tag and exception code, with whole-pipe flush and a saturating count of
// beats killed by flush.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : pipe_stage_reg_if.slave (in_* / out_* handshake, flush,
//             drop_count)
// Build option PIPE_STAGE_SKID_EN adds a skid entry S behind the main entry M
// so in_ready becomes a pure register output. Without it, in_ready is
// combinational from out_ready.
module pipe_stage_reg
  import core_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int TAG_W  = CORE_TAG_W,
  parameter int EXC_W  = CORE_EXC_W,
  parameter int CNT_W  = 16
) (
  input logic             clk,
  input logic             reset_n,
  pipe_stage_reg_if.slave bus
);
  localparam int PW = DATA_W + TAG_W + EXC_W;

  logic [PW-1:0]    in_pl, m_pl, m_din;
  logic             m_v, m_free, m_vin;
  logic             in_ready, in_fire;
  logic [1:0]       kill_n;
  logic [CNT_W:0]   cnt_sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign in_pl   = {bus.in_data, bus.in_tag, bus.in_exc};
  // M may take a new value when it is empty or its beat leaves this cycle.
  assign m_free  = !m_v || bus.out_ready;
  assign in_fire = bus.in_valid && in_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic          s_v, s_clear, s_load;
  logic [PW-1:0] s_pl;

  assign in_ready = !s_v;
  // S is older than any input, so it has first claim on a freed M. While S
  // is valid in_ready is low, so no input can compete for M in that cycle.
  assign m_vin    = s_v || in_fire;
  assign m_din    = s_v ? s_pl : in_pl;
  assign s_load   = !m_free && in_fire;
  assign s_clear  = bus.flush || (m_free && s_v);
  // Any beat on in_* during flush is discarded, held back or not.
  assign kill_n   = {1'b0, m_v} + {1'b0, s_v} + {1'b0, bus.in_valid};

  pipe_skid_entry #(.W(PW)) u_s (
    .clk     (clk),
    .rst_n   (reset_n),
    .clear_i (s_clear),
    .load_i  (s_load),
    .valid_i (1'b1),
    .data_i  (in_pl),
    .valid_o (s_v),
    .data_o  (s_pl)
  );
`else
  assign in_ready = m_free;
  assign m_vin    = in_fire;
  assign m_din    = in_pl;
  assign kill_n   = {1'b0, m_v} + {1'b0, bus.in_valid};
`endif

  pipe_skid_entry #(.W(PW)) u_m (
    .clk     (clk),
    .rst_n   (reset_n),
    .clear_i (bus.flush),
    .load_i  (m_free),
    .valid_i (m_vin),
    .data_i  (m_din),
    .valid_o (m_v),
    .data_o  (m_pl)
  );

  // Saturating drop counter: the extra sum bit flags overflow past all-ones.
  always_comb begin
    cnt_sum = {1'b0, cnt_q} + {{(CNT_W-1){1'b0}}, kill_n};
    cnt_d   = cnt_q;
    if (bus.flush) begin
      cnt_d = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = m_v;
  assign {bus.out_data, bus.out_tag, bus.out_exc} = m_pl;
  assign bus.drop_count = cnt_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
  import core_pkg::*;

  localparam int DATA_W = 64;
  localparam int TAG_W  = 4;
  localparam int EXC_W  = 3;
  localparam int CNT_W  = 16;

`ifdef PIPE_STAGE_SKID_EN
  localparam int FULL_KILL = 3;
`else
  localparam int FULL_KILL = 2;
`endif

  logic clk;
  logic reset_n;
  int   total;
  int   bad;
  int   exp_drop;

  pipe_stage_reg_if #(.DATA_W(DATA_W), .TAG_W(TAG_W), .EXC_W(EXC_W), .CNT_W(CNT_W)) bus ();

  pipe_stage_reg #(.DATA_W(DATA_W), .TAG_W(TAG_W), .EXC_W(EXC_W), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one cycle: wait for the active edge, then settle 1 time unit past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_in(input logic v, input rob_tag_t t, input logic [63:0] d, input exc_t e);
    bus.in_valid = v;
    bus.in_tag   = t;
    bus.in_data  = d;
    bus.in_exc   = e;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    exp_drop = 0;
    reset_n  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    drive_in(1'b0, '0, '0, EXC_NONE);

    // reset state
    #3;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", bus.out_data, 64'd0);
    check("rst_out_tag", 64'(bus.out_tag), 64'd0);
    check("rst_out_exc", 64'(bus.out_exc), 64'd0);
    check("rst_drop", 64'(bus.drop_count), 64'd0);
    #9 reset_n = 1'b1;
    step();
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // streaming tags 0..9, one cycle latency, no bubbles
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_in(1'b1, rob_tag_t'(i), 64'hA000 + 64'(i), exc_t'(i % 8));
      #1;
      check("stream_in_ready", 64'(bus.in_ready), 64'd1);
      step();
      check("stream_valid", 64'(bus.out_valid), 64'd1);
      check("stream_tag", 64'(bus.out_tag), 64'(i));
      check("stream_data", bus.out_data, 64'hA000 + 64'(i));
      check("stream_exc", 64'(bus.out_exc), 64'(i % 8));
    end
    drive_in(1'b0, '0, '0, EXC_NONE);
    step();
    check("stream_drained", 64'(bus.out_valid), 64'd0);

    // back-pressure: A (tag 1) then B (tag 2) with out_ready low
    bus.out_ready = 1'b0;
    drive_in(1'b1, 4'd1, 64'hAAAA, EXC_NONE);
    #1;
    check("bp_ready_a", 64'(bus.in_ready), 64'd1);
    step();
    check("bp_m_a_valid", 64'(bus.out_valid), 64'd1);
    check("bp_m_a_tag", 64'(bus.out_tag), 64'd1);
    drive_in(1'b1, 4'd2, 64'hBBBB, EXC_NONE);
`ifdef PIPE_STAGE_SKID_EN
    #1;
    check("bp_ready_b", 64'(bus.in_ready), 64'd1);
    step();
    check("bp_hold_a", 64'(bus.out_tag), 64'd1);
    check("bp_ready_low", 64'(bus.in_ready), 64'd0);
    drive_in(1'b0, '0, '0, EXC_NONE);
    step();
    check("bp_hold_a2", 64'(bus.out_tag), 64'd1);
    check("bp_ready_low2", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    step();
    check("bp_out_b_valid", 64'(bus.out_valid), 64'd1);
    check("bp_out_b_tag", 64'(bus.out_tag), 64'd2);
    check("bp_out_b_data", bus.out_data, 64'hBBBB);
    check("bp_ready_back", 64'(bus.in_ready), 64'd1);
`else
    #1;
    check("bp_ready_low", 64'(bus.in_ready), 64'd0);
    step();
    check("bp_hold_a", 64'(bus.out_tag), 64'd1);
    bus.out_ready = 1'b1;
    #1;
    check("bp_ready_back", 64'(bus.in_ready), 64'd1);
    step();
    check("bp_out_b_valid", 64'(bus.out_valid), 64'd1);
    check("bp_out_b_tag", 64'(bus.out_tag), 64'd2);
    check("bp_out_b_data", bus.out_data, 64'hBBBB);
    drive_in(1'b0, '0, '0, EXC_NONE);
`endif
    step();
    check("bp_drained", 64'(bus.out_valid), 64'd0);

    // flush with full buffers plus an incoming beat
    bus.out_ready = 1'b0;
    drive_in(1'b1, 4'd3, 64'h3333, EXC_NONE);
    step();
    drive_in(1'b1, 4'd4, 64'h4444, EXC_NONE);
    step();
    check("fl_pre_valid", 64'(bus.out_valid), 64'd1);
    check("fl_pre_tag", 64'(bus.out_tag), 64'd3);
    drive_in(1'b1, 4'd5, 64'h5555, EXC_NONE);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    drive_in(1'b0, '0, '0, EXC_NONE);
    exp_drop = FULL_KILL;
    check("fl_full_valid", 64'(bus.out_valid), 64'd0);
    check("fl_full_drop", 64'(bus.drop_count), 64'(exp_drop));
    check("fl_full_in_ready", 64'(bus.in_ready), 64'd1);
    // stage still works after flush
    bus.out_ready = 1'b1;
    drive_in(1'b1, 4'd6, 64'h6666, EXC_NONE);
    step();
    drive_in(1'b0, '0, '0, EXC_NONE);
    check("fl_after_tag", 64'(bus.out_tag), 64'd6);
    check("fl_after_valid", 64'(bus.out_valid), 64'd1);
    step();

    // flush with empty stage and no input
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("fl_empty_drop", 64'(bus.drop_count), 64'(exp_drop));
    check("fl_empty_valid", 64'(bus.out_valid), 64'd0);

    // saturation: climb to 0xFFFE one killed input per flush
    bus.out_ready = 1'b0;
    bus.flush = 1'b1;
    drive_in(1'b1, 4'd9, 64'h9999, EXC_NONE);
    for (int i = 0; i < 'hFFFE - FULL_KILL; i++) step();
    bus.flush = 1'b0;
    exp_drop = 'hFFFE;
    check("sat_preload", 64'(bus.drop_count), 64'(exp_drop));
    step();  // loads M
    check("sat_m_loaded", 64'(bus.out_valid), 64'd1);
    bus.flush = 1'b1;
    step();  // kills M and the input: 0xFFFE + 2 saturates
    check("sat_hit", 64'(bus.drop_count), 64'hFFFF);
    step();
    check("sat_hold", 64'(bus.drop_count), 64'hFFFF);
    bus.flush = 1'b0;
    drive_in(1'b0, '0, '0, EXC_NONE);
    step();

    // async reset while stalled with buffers full
    drive_in(1'b1, 4'd7, 64'h7777, EXC_NONE);
    step();
    drive_in(1'b1, 4'd8, 64'h8888, EXC_NONE);
    step();
    drive_in(1'b0, '0, '0, EXC_NONE);
    check("ar_pre_valid", 64'(bus.out_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("ar_valid", 64'(bus.out_valid), 64'd0);
    check("ar_drop", 64'(bus.drop_count), 64'd0);
    #2 reset_n = 1'b1;
    step();
    check("ar_in_ready", 64'(bus.in_ready), 64'd1);
    check("ar_valid_after", 64'(bus.out_valid), 64'd0);
    check("ar_drop_after", 64'(bus.drop_count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
